// File: rtl/noc_eject_collector.sv
// noc_eject_collector: ejection-side network interface for one CONNECT
// receive port. Buffers flits per VC (VC0 = operand A, VC1 = operand B),
// presents matched A/B pairs over valid/ready and returns one credit per
// freed slot, round-robin between VCs when both have credits pending.
// Optional macro EJECT_DEST_CHECK_EN: flits whose dest differs from NODE_ID
// are dropped, flag dest_err, and still have their credit returned.

module noc_eject_collector #(
    parameter logic [3:0]  NODE_ID = 4'd0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [70:0] flit_in,
    output logic        get_en,
    output logic [1:0]  credit_out,
    output logic        credit_en,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [63:0] op_a,
    output logic [63:0] op_b,
    output logic        ovf_err,
    output logic        dest_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [63:0]   mem_q   [2][DEPTH];
    logic [63:0]   mem_d   [2][DEPTH];
    logic [AW-1:0] wp_q    [2];
    logic [AW-1:0] wp_d    [2];
    logic [AW-1:0] rp_q    [2];
    logic [AW-1:0] rp_d    [2];
    logic [PW-1:0] cnt_q   [2];
    logic [PW-1:0] cnt_d   [2];
    logic [PW-1:0] pend_q  [2];
    logic [PW-1:0] pend_d  [2];
    logic [PW:0]   pend_nx [2];

    logic rr_q, rr_d;
    logic get_en_q, get_en_d;
    logic cred_en_q, cred_en_d;
    logic cred_vc_q, cred_vc_d;
    logic ovf_q, ovf_d;
    logic derr_q, derr_d;

    logic       dest_ok;
    logic       pop;
    logic       both_pend;
    logic [1:0] push_req;
    logic [1:0] drop;
    logic [1:0] dec;
    logic [1:0] accept;

`ifdef EJECT_DEST_CHECK_EN
    assign dest_ok = (flit_in[68:65] == NODE_ID);
    logic unused_tail;
    assign unused_tail = flit_in[69];
`else
    assign dest_ok = 1'b1;
    logic unused_dest;
    assign unused_dest = ^{flit_in[69:65], NODE_ID};
`endif

    // Pair presentation straight from the registered FIFO heads
    always_comb begin
        op_valid = (cnt_q[0] != '0) && (cnt_q[1] != '0);
        op_a     = (cnt_q[0] != '0) ? mem_q[0][rp_q[0]] : '0;
        op_b     = (cnt_q[1] != '0) ? mem_q[1][rp_q[1]] : '0;
        pop      = op_valid && op_ready;
    end

    // Credit decision from counters as they stand before this edge
    always_comb begin
        get_en_d  = 1'b1;
        both_pend = (pend_q[0] != '0) && (pend_q[1] != '0);
        cred_en_d = (pend_q[0] != '0) || (pend_q[1] != '0);
        rr_d      = rr_q;
        if (both_pend) begin
            cred_vc_d = rr_q;
            rr_d      = ~rr_q;
        end else begin
            cred_vc_d = (pend_q[1] != '0);
        end
    end

    // Per-VC decode of the incoming flit and of the credit being issued
    always_comb begin
        push_req = '0;
        drop     = '0;
        dec      = '0;
        for (int unsigned v = 0; v < 2; v++) begin
            push_req[v[0]] = flit_in[70] && (flit_in[64] == v[0]) && dest_ok;
            drop[v[0]]     = flit_in[70] && (flit_in[64] == v[0]) && !dest_ok;
            dec[v[0]]      = cred_en_d && (cred_vc_d == v[0]);
        end
    end

    // FIFO push/pop, occupancy, pending credits and sticky error flags
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pend_nx = '{default: '0};
        accept  = '0;
        ovf_d   = ovf_q;
        derr_d  = derr_q;
        for (int unsigned v = 0; v < 2; v++) begin
            // fullness is judged before the pop, but a simultaneous pop frees the slot
            accept[v[0]] = push_req[v[0]] && ((cnt_q[v[0]] != FULL_CNT) || pop);
            if (push_req[v[0]] && !accept[v[0]]) ovf_d = 1'b1;
            if (drop[v[0]]) derr_d = 1'b1;
            if (accept[v[0]]) begin
                mem_d[v[0]][wp_q[v[0]]] = flit_in[63:0];
                wp_d[v[0]] = wp_q[v[0]] + AW'(1);
            end
            if (pop) rp_d[v[0]] = rp_q[v[0]] + AW'(1);
            if (accept[v[0]] && !pop) begin
                cnt_d[v[0]] = cnt_q[v[0]] + PW'(1);
            end else if (!accept[v[0]] && pop) begin
                cnt_d[v[0]] = cnt_q[v[0]] - PW'(1);
            end
            pend_nx[v[0]] = {1'b0, pend_q[v[0]]} + (PW+1)'(pop)
                          + (PW+1)'(drop[v[0]]) - (PW+1)'(dec[v[0]]);
            pend_d[v[0]]  = pend_nx[v[0]][PW-1:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (reset) begin
            mem_q     <= '{default: '0};
            wp_q      <= '{default: '0};
            rp_q      <= '{default: '0};
            cnt_q     <= '{default: '0};
            pend_q    <= '{default: '0};
            rr_q      <= 1'b0;
            get_en_q  <= 1'b0;
            cred_en_q <= 1'b0;
            cred_vc_q <= 1'b0;
            ovf_q     <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            get_en_q  <= get_en_d;
            cred_en_q <= cred_en_d;
            cred_vc_q <= cred_vc_d;
            ovf_q     <= ovf_d;
            derr_q    <= derr_d;
        end
    end

    // Pending credits can never exceed the router's initial credit count
    always_ff @(posedge Clk) begin
        if (!reset) begin
            assert (pend_nx[0] <= (PW+1)'(DEPTH));
            assert (pend_nx[1] <= (PW+1)'(DEPTH));
        end
    end

    assign get_en     = get_en_q;
    assign credit_en  = cred_en_q;
    assign credit_out = {cred_en_q, cred_vc_q};
    assign ovf_err    = ovf_q;
    assign dest_err   = derr_q;

endmodule
